// File: rtl/ysyx_22050133_mem_resp.sv
// Burst memory responder for the cache's axi_rw bus: accepts one request, then
// serves len+1 read or write beats from/into an internal 64-bit word array.
module ysyx_22050133_mem_resp #(
    parameter int RW_DATA_WIDTH = 64,
    parameter int RW_ADDR_WIDTH = 32,
    parameter int MEM_AW        = 10,
    parameter int RD_LAT        = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rw_addr_valid_i,
    output logic                     rw_addr_ready_o,
    input  logic [RW_ADDR_WIDTH-1:0] rw_addr_i,
    input  logic                     rw_we_i,
    input  logic [7:0]               rw_len_i,
    input  logic [2:0]               rw_size_i,
    input  logic [1:0]               rw_burst_i,
    input  logic                     rw_if_i,
    input  logic                     w_data_valid_i,
    output logic                     w_data_ready_o,
    input  logic [RW_DATA_WIDTH-1:0] w_data_i,
    output logic                     r_data_valid_o,
    input  logic                     r_data_ready_i,
    output logic [RW_DATA_WIDTH-1:0] r_data_o,
    input  logic                     rw_block_i,
    output logic                     rw_block_o
);

    typedef enum logic [1:0] {IDLE, RLAT, RD, WR} state_e;

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = (RD_LAT > 0) ? LAT_W'(RD_LAT - 1) : '0;

    logic [RW_DATA_WIDTH-1:0] mem [2**MEM_AW];

    state_e                   state_q, state_d;
    logic [RW_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [7:0]               cnt_q, cnt_d;
    logic [LAT_W-1:0]         lat_q, lat_d;
    logic [2:0]               size_q, size_d;
    logic [1:0]               burst_q, burst_d;
    logic                     if_q, if_d;
    logic                     r_valid_q, r_valid_d;
    logic [RW_DATA_WIDTH-1:0] r_data_q, r_data_d;

    logic                     addr_hs;
    logic                     mem_we;
    logic [1:0]               size_eff;
    logic [7:0]               lanes;
    logic [7:0]               bmask;
    logic [RW_ADDR_WIDTH-1:0] next_addr;
    logic [MEM_AW-1:0]        cur_idx, next_idx, req_idx;
    logic                     unused_if;

    assign rw_addr_ready_o = (state_q == IDLE) & ~rw_block_i & ~rst;
    assign w_data_ready_o  = (state_q == WR) & ~rst;
    assign r_data_valid_o  = r_valid_q & ~rst;
    assign r_data_o        = rst ? '0 : r_data_q;
    assign rw_block_o      = (state_q != IDLE) & ~rst;

    assign addr_hs = rw_addr_valid_i & rw_addr_ready_o;
    // Gating with rst keeps a beat presented in the reset cycle out of the array.
    assign mem_we  = (state_q == WR) & w_data_valid_i & ~rst;

    assign size_eff  = (size_q > 3'd3) ? 2'd3 : size_q[1:0];
    assign next_addr = (burst_q == 2'b00) ? cur_addr_q
                                          : cur_addr_q + (RW_ADDR_WIDTH'(1) << size_eff);
    assign cur_idx   = cur_addr_q[MEM_AW+2:3];
    assign next_idx  = next_addr[MEM_AW+2:3];
    assign req_idx   = rw_addr_i[MEM_AW+2:3];
    assign unused_if = if_q;

    always_comb begin
        case (size_eff)
            2'd0:    lanes = 8'h01;
            2'd1:    lanes = 8'h03;
            2'd2:    lanes = 8'h0F;
            default: lanes = 8'hFF;
        endcase
        bmask = (size_eff == 2'd3) ? 8'hFF : (lanes << cur_addr_q[2:0]);
    end

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        size_d     = size_q;
        burst_d    = burst_q;
        if_d       = if_q;
        r_valid_d  = r_valid_q;
        r_data_d   = r_data_q;
        case (state_q)
            IDLE: begin
                if (addr_hs) begin
                    cur_addr_d = rw_addr_i;
                    cnt_d      = rw_len_i;
                    size_d     = rw_size_i;
                    burst_d    = rw_burst_i;
                    if_d       = rw_if_i;
                    if (rw_we_i) begin
                        state_d = WR;
                    end else if (RD_LAT > 0) begin
                        state_d = RLAT;
                        lat_d   = LAT_INIT;
                    end else begin
                        state_d   = RD;
                        r_valid_d = 1'b1;
                        r_data_d  = mem[req_idx];
                    end
                end
            end
            RLAT: begin
                if (lat_q == '0) begin
                    state_d   = RD;
                    r_valid_d = 1'b1;
                    r_data_d  = mem[cur_idx];
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            RD: begin
                if (r_data_ready_i) begin
                    if (cnt_q == 8'd0) begin
                        state_d   = IDLE;
                        r_valid_d = 1'b0;
                    end else begin
                        cnt_d      = cnt_q - 8'd1;
                        cur_addr_d = next_addr;
                        r_data_d   = mem[next_idx];
                    end
                end
            end
            WR: begin
                if (w_data_valid_i) begin
                    if (cnt_q == 8'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d      = cnt_q - 8'd1;
                        cur_addr_d = next_addr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            cnt_q      <= '0;
            lat_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            if_q       <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            cnt_q      <= cnt_d;
            lat_q      <= lat_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            if_q       <= if_d;
            r_valid_q  <= r_valid_d;
            r_data_q   <= r_data_d;
        end
    end

    // Array is deliberately not reset; it models plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (bmask[b]) mem[cur_idx][8*b +: 8] <= w_data_i[8*b +: 8];
            end
        end
    end

endmodule

// File: doc/ysyx_22050133_mem_resp.md
# ysyx_22050133_mem_resp

Burst memory responder for the cache's downstream `axi_rw_*` bus. It accepts the single-address-channel request (`we` selects read or write), then serves `len+1` data beats from or into an internal 64-bit word array. It is the device end of the interface the cache drives as initiator. It serves as the memory model behind the instruction and data caches in simulation, and as the on-chip scratch memory.

## Interface
Parameters:
- `RW_DATA_WIDTH`, 64, data beat width; fixed at 64.
- `RW_ADDR_WIDTH`, 32, byte address width.
- `MEM_AW`, 10, word-index width; the array holds 2^MEM_AW 64-bit words.
- `RD_LAT`, 2, idle cycles between read-address accept and the first read beat; 0 is legal.

Ports:
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `rw_addr_valid_i` in 1: request valid.
- `rw_addr_ready_o` out 1: request accepted on `valid & ready`.
- `rw_addr_i` in RW_ADDR_WIDTH: start byte address.
- `rw_we_i` in 1: 1 = write burst, 0 = read burst.
- `rw_len_i` in 8: beats minus one.
- `rw_size_i` in 3: bytes per beat = 2^size (0..3).
- `rw_burst_i` in 2: 00 FIXED; 01 INCR; 10/11 treated as INCR.
- `rw_if_i` in 1: instruction-fetch tag; latched only, no effect on behaviour.
- `w_data_valid_i` in 1: write beat valid.
- `w_data_ready_o` out 1: write beat ready.
- `w_data_i` in 64: write data, byte-lane aligned (byte k on bits 8k+7:8k).
- `r_data_valid_o` out 1: read beat valid.
- `r_data_ready_i` in 1: read beat ready.
- `r_data_o` out 64: full aligned 64-bit word at the current beat address.
- `rw_block_i` in 1: initiator requests a hold; no new request is accepted while high.
- `rw_block_o` out 1: high whenever a burst is in progress (state != IDLE).

## Operation
States: IDLE, RLAT, RD, WR.

- **IDLE**
  - `rw_addr_ready_o = (state==IDLE) & ~rw_block_i & ~rst`, combinational.
  - On accept, latch `cur_addr = rw_addr_i`, `cnt = rw_len_i`, and also latch `size`, `burst`, `if`.
  - `we=1` → WR.
  - `we=0` and `RD_LAT>0` → RLAT with `lat = RD_LAT-1`.
  - `we=0` and `RD_LAT==0` → RD; register `r_data_o = mem[idx]` and set `r_data_valid_o=1`.
- **RLAT**
  - Decrement `lat` each cycle.
  - At `lat==0`: → RD, load `r_data_o`, set `r_data_valid_o=1`.
- **RD**
  - `r_data_valid_o` stays high until the beat handshakes.
  - `r_data_o` holds stable while valid and not ready.
  - On handshake with `cnt==0`: → IDLE, `r_data_valid_o=0`.
  - On handshake with `cnt!=0`: `cnt-=1`, advance address, load the next word; valid stays 1, so the next beat is presented the following cycle.
  - The initiator may drop ready between beats; this must not lose or repeat a beat.
- **WR**
  - `w_data_ready_o = (state==WR)`, combinational.
  - On handshake, write bytes of `mem[idx]` selected by `bmask`.
  - With `cnt==0` → IDLE; otherwise `cnt-=1` and advance the address.
  - Initiator gaps in `w_data_valid_i` are allowed.
- **Index and byte mask**
  - `idx = cur_addr[MEM_AW+2:3]`; higher address bits are ignored, so the array aliases modulo its size.
  - `bmask = (8'hFF >> (8 - 2^size)) << cur_addr[2:0]`, truncated to 8 bits.
  - Size 3 forces the mask to FF regardless of `addr[2:0]`.
- **Address advance**
  - INCR: `cur_addr += 2^size`, wrapping modulo 2^RW_ADDR_WIDTH. The index therefore wraps from 2^MEM_AW-1 to 0.
  - FIXED: the address is unchanged.
- **Ignored inputs**
  - `w_data_valid_i` outside WR is ignored, and no write occurs.
  - `r_data_ready_i` outside RD is ignored.
- **Reset**
  - Output values during reset: `rw_addr_ready_o=0`, `w_data_ready_o=0`, `r_data_valid_o=0`, `r_data_o=0`, `rw_block_o=0`.
  - Reset forces state to IDLE and clears `cnt`, `lat` and `cur_addr`.
  - Array contents are not reset.
  - Reset mid-burst abandons the burst. Beats already written stay written, and there is no partial-beat write in the reset cycle.

## Timing
- Address accepted at edge t:
  - Write: `w_data_ready_o` is first high in cycle t+1.
  - Read: `r_data_valid_o` is first high in cycle t+1+RD_LAT.
- **Read throughput:** one beat per cycle when `r_data_ready_i` is held high. An N-beat read occupies RD for exactly N cycles.
- **Write throughput:** one beat per cycle when `w_data_valid_i` is held high.
- After the last beat handshakes at edge e, `rw_addr_ready_o` is high in cycle e+1 (if `rw_block_i` is low). There is no back-to-back accept in the same cycle as the last beat.
- **Write-to-read ordering:** a write beat accepted at edge e is visible to any read word loaded at or after edge e+1.

## Test plan
1. INCR write, `len=7`, `size=3`, addr 0x80000040, data 0x1111…×k for beat k → INCR read of the same range returns those 8 words in order, with `r_data_valid_o` first high at t+3 (RD_LAT=2).
2. Word 0x80000000 preloaded to 0; `size=0` write at 0x80000003 with `w_data_i=0xAB000000` → a read of 0x80000000 returns 0x00000000AB000000.
3. 4-beat read with `r_data_ready_i` toggling 1,0,1,0… → each beat is presented exactly once, and `r_data_o` is stable while stalled.
4. `rw_block_i=1` with `rw_addr_valid_i=1` in IDLE → `rw_addr_ready_o=0` and no state change. Releasing the block → accept the next cycle.
5. `rst` asserted during beat 3 of an 8-beat write → all outputs are at reset values the next cycle, and beats 0–2 are read back correctly.
6. INCR read, `len=1`, starting at index 2^MEM_AW-1 → the second beat returns word 0. A FIXED write, `len=2` → only the last beat's data remains at that address.
